// File: rtl/tsp_arb_pkg.sv
// Shared types for the logic_ram arbiter: FSM states, read-return tag, fixed AXI requester slots.
// Pure declarations; no timing or backpressure of its own.
package tsp_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Tag index width bounds NUM_REQ to 16 requesters.
   localparam int TAG_IDX_BITS = 4;

   typedef struct packed {
      logic                    valid;
      logic [TAG_IDX_BITS-1:0] index;
   } rd_tag_t;

   localparam int REQ_AXI_RD = 0;
   localparam int REQ_AXI_WR = 1;

endpackage

// File: rtl/tsp_rr_pick.sv
// One-hot round-robin selector: first set bit of req_vec searching upward from ptr, wrapping at N.
// Purely combinational, zero latency; nothing is held, pick_vld low when req_vec is empty.
module tsp_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_vec,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  pick_oh,
   output logic [IW-1:0] pick_idx,
   output logic          pick_vld
);

   logic [IW-1:0] j_idx;

   always_comb begin
      pick_oh  = '0;
      pick_idx = '0;
      pick_vld = 1'b0;
      j_idx    = '0;
      for (int k = 0; k < N; k++) begin
         j_idx = IW'((int'(ptr) + k) % N);
         if (!pick_vld && req_vec[j_idx]) begin
            pick_vld       = 1'b1;
            pick_oh[j_idx] = 1'b1;
            pick_idx       = j_idx;
         end
      end
   end

endmodule

// File: rtl/tsp_ram_arbiter.sv
// Round-robin share of the logic_ram port with bounded burst lock; TSP_ARB_AXI_PRIORITY_EN favours AXI slots 0/1.
// Access hits the RAM one cycle after gnt, tagged read data returns two cycles after gnt; losers hold req until gnt.
module tsp_ram_arbiter
   import tsp_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_BITS  = 11,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              req_lock,
   input  logic [NUM_REQ-1:0]              req_we,
   input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
   output logic [NUM_REQ-1:0]              gnt,
   output logic [NUM_REQ-1:0]              rd_valid,
   output logic [DATA_WIDTH-1:0]           rd_data,
   output logic                            mem_rden,
   output logic                            mem_wren,
   output logic [ADDR_BITS-1:0]            mem_address,
   output logic [DATA_WIDTH-1:0]           mem_wdata,
   output logic [DATA_WIDTH/8-1:0]         mem_wstrb,
   input  logic [DATA_WIDTH-1:0]           mem_rdata
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SW = DATA_WIDTH / 8;
   localparam int BW = $clog2(MAX_BURST);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

   arb_state_e    state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] owner;
   logic [BW-1:0] burst_cnt;
   logic [BW-1:0] cnt_nxt;
   rd_tag_t       tag_q1;
   rd_tag_t       tag_q2;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IW-1:0]      pick_idx;
   logic               pick_vld;

`ifdef TSP_ARB_AXI_PRIORITY_EN
   localparam logic [NUM_REQ-1:0] AXI_MASK =
      NUM_REQ'((1 << REQ_AXI_RD) | (1 << REQ_AXI_WR));

   logic [NUM_REQ-1:0] axi_oh, oth_oh;
   logic [IW-1:0]      axi_idx, oth_idx;
   logic               axi_vld, oth_vld;

   // Both groups rotate off the shared ptr; AXI wins whenever it has anything pending.
   tsp_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_axi (
      .req_vec (req & AXI_MASK),
      .ptr     (ptr),
      .pick_oh (axi_oh),
      .pick_idx(axi_idx),
      .pick_vld(axi_vld)
   );

   tsp_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_oth (
      .req_vec (req & ~AXI_MASK),
      .ptr     (ptr),
      .pick_oh (oth_oh),
      .pick_idx(oth_idx),
      .pick_vld(oth_vld)
   );

   assign pick_oh  = axi_vld ? axi_oh  : oth_oh;
   assign pick_idx = axi_vld ? axi_idx : oth_idx;
   assign pick_vld = axi_vld | oth_vld;
`else
   tsp_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req_vec (req),
      .ptr     (ptr),
      .pick_oh (pick_oh),
      .pick_idx(pick_idx),
      .pick_vld(pick_vld)
   );
`endif

   logic          acc;
   logic [IW-1:0] win_idx;
   logic          win_we;
   logic          win_lock;

   assign win_idx  = (state == ARB) ? pick_idx : owner;
   assign acc      = (state == ARB) ? pick_vld : req[owner];
   assign win_we   = req_we[win_idx];
   assign win_lock = req_lock[win_idx];
   assign cnt_nxt  = burst_cnt + 1'b1;

   always_comb begin
      gnt = '0;
      if (state == ARB)
         gnt = pick_oh;
      else if (req[owner])
         gnt[owner] = 1'b1;
      // Grants are withheld while the port is held in reset.
      gnt = gnt & {NUM_REQ{S_AXI_ARESETN}};
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state       <= ARB;
         ptr         <= '0;
         owner       <= '0;
         burst_cnt   <= '0;
         mem_rden    <= 1'b0;
         mem_wren    <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         mem_wstrb   <= '0;
         tag_q1      <= '0;
         tag_q2      <= '0;
      end else begin
         mem_rden     <= acc & ~win_we;
         mem_wren     <= acc & win_we;
         tag_q1.valid <= acc & ~win_we;
         tag_q1.index <= TAG_IDX_BITS'(win_idx);
         tag_q2       <= tag_q1;
         if (acc) begin
            mem_address <= req_addr[win_idx*ADDR_BITS +: ADDR_BITS];
            mem_wdata   <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
            mem_wstrb   <= req_wstrb[win_idx*SW +: SW];
         end
         case (state)
            ARB: begin
               if (acc) begin
                  ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                  // With MAX_BURST of 2 the first grant already exhausts the budget.
                  if (win_lock && (MAX_BURST > 2)) begin
                     state     <= LOCKED;
                     owner     <= win_idx;
                     burst_cnt <= BW'(1);
                  end
               end
            end
            LOCKED: begin
               if (!req[owner]) begin
                  state <= ARB;
               end else begin
                  burst_cnt <= cnt_nxt;
                  if (!win_lock || (cnt_nxt == BURST_LAST))
                     state <= ARB;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   always_comb begin
      rd_valid = '0;
      for (int i = 0; i < NUM_REQ; i++)
         rd_valid[i] = tag_q2.valid && (tag_q2.index == TAG_IDX_BITS'(i));
      rd_data = tag_q2.valid ? mem_rdata : '0;
   end

endmodule
